// File: rtl/dii_package.sv
// Shared flit type for the debug interconnect interface (DII).
package dii_package;

  // One DII flit: valid qualifier, end-of-packet marker and 16-bit payload.
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

endpackage

// File: rtl/osd_rr_arb.sv
// Combinational round-robin picker: first set bit of req at or above ptr,
// wrapping modulo N.
module osd_rr_arb #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IW = $clog2(N);

  int idx;

  // Scan from the farthest offset down so the closest requester to ptr wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N;
      if (req[IW'(idx)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/osd_dii_pkt_arbiter.sv
// Packet-granular round-robin merge of N DII flit streams into one
// registered output stream.
//
// Handshake: a flit moves across an interface in a cycle where its valid
// and the matching ready are both high at the rising clock edge. Ready
// never depends on the requester's own valid, only on grant/ownership and
// on whether the output register can take a flit this cycle.
module osd_dii_pkt_arbiter
  import dii_package::*;
#(
  parameter int N = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  dii_flit [N-1:0]      debug_in,
  output logic [N-1:0]         debug_in_ready,
  output dii_flit              debug_out,
  input  logic                 debug_out_ready,
  output logic [$clog2(N)-1:0] owner,
  output logic                 locked
);

  localparam int IW = $clog2(N);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] owner_q;
  dii_flit       out_q;

  logic [N-1:0]  req;
  logic          gnt_valid;
  logic [IW-1:0] gnt_idx;
  logic          sel_en;
  logic [IW-1:0] sel_idx;
  logic [IW-1:0] sel_idx_inc;
  dii_flit       sel_flit;
  logic          can_take;
  logic          accept;

  // Request vector for the round-robin picker.
  always_comb begin
    req = '0;
    for (int i = 0; i < N; i++) begin
      req[i] = debug_in[i].valid;
    end
  end

  osd_rr_arb #(.N(N)) u_rr_arb (
    .req       (req),
    .ptr       (rr_ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Pick the active requester: the owner while locked, else the fresh grant.
  always_comb begin
    sel_en      = 1'b0;
    sel_idx     = '0;
    sel_flit    = '0;
    sel_idx_inc = '0;
    if (state == LOCK) begin
      sel_en  = 1'b1;
      sel_idx = owner_q;
    end else begin
      sel_en  = gnt_valid;
      sel_idx = gnt_idx;
    end
    sel_flit    = debug_in[sel_idx];
    sel_idx_inc = (sel_idx == IW'(N - 1)) ? '0 : sel_idx + IW'(1);
  end

  // Output register can take a flit when empty or being drained this cycle.
  // Reset gates ready so nothing is offered while the block is held in reset.
  always_comb begin
    debug_in_ready = '0;
    can_take       = !out_q.valid || debug_out_ready;
    accept         = 1'b0;
    if (rst && sel_en && can_take) begin
      debug_in_ready[sel_idx] = 1'b1;
      accept                  = sel_flit.valid;
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Lock on the first flit of a multi-flit packet, release on its last flit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !sel_flit.last) state_nxt = LOCK;
      LOCK:    if (accept && sel_flit.last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Round-robin pointer moves only past a completed packet; owner latches at lock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr  <= '0;
      owner_q <= '0;
    end else begin
      if (accept && sel_flit.last) begin
        rr_ptr <= sel_idx_inc;
      end
      if (state == IDLE && accept && !sel_flit.last) begin
        owner_q <= gnt_idx;
      end
    end
  end

  // Output register: load on accept, clear valid on drain, otherwise hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
    end else if (accept) begin
      out_q       <= sel_flit;
      out_q.valid <= 1'b1;
    end else if (debug_out_ready) begin
      out_q.valid <= 1'b0;
    end
  end

  assign debug_out = out_q;
  assign owner     = owner_q;
  assign locked    = (state == LOCK);

endmodule

// File: tb/tb_osd_dii_pkt_arbiter.sv
// Directed bench for osd_dii_pkt_arbiter with N=2 and N=4 instances.
module tb_osd_dii_pkt_arbiter;
  import dii_package::*;

  localparam int W = 17;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  dii_flit [1:0] d2_in;
  logic    [1:0] d2_ready;
  dii_flit       d2_out;
  logic          d2_out_ready;
  logic          d2_owner;
  logic          d2_locked;

  dii_flit [3:0] d4_in;
  logic    [3:0] d4_ready;
  dii_flit       d4_out;
  logic          d4_out_ready;
  logic    [1:0] d4_owner;
  logic          d4_locked;

  osd_dii_pkt_arbiter #(.N(2)) u_dut2 (
    .clk             (clk),
    .rst             (rst),
    .debug_in        (d2_in),
    .debug_in_ready  (d2_ready),
    .debug_out       (d2_out),
    .debug_out_ready (d2_out_ready),
    .owner           (d2_owner),
    .locked          (d2_locked)
  );

  osd_dii_pkt_arbiter #(.N(4)) u_dut4 (
    .clk             (clk),
    .rst             (rst),
    .debug_in        (d4_in),
    .debug_in_ready  (d4_ready),
    .debug_out       (d4_out),
    .debug_out_ready (d4_out_ready),
    .owner           (d4_owner),
    .locked          (d4_locked)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp2_q[$];
  logic [W-1:0] exp4_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic dii_flit mk(input logic last, input logic [15:0] data);
    dii_flit f;
    f.valid = 1'b1;
    f.last  = last;
    f.data  = data;
    return f;
  endfunction

  function automatic logic [W-1:0] fl(input dii_flit f);
    return {f.last, f.data};
  endfunction

  // Output monitors: a flit leaves when valid and ready are high at the edge.
  always @(negedge clk) begin
    if (rst && d2_out.valid && d2_out_ready) begin
      if (exp2_q.size() == 0) check("d2_extra_flit", 32'(d2_out.valid), 32'd0);
      else                    check("d2_out_flit", 32'(fl(d2_out)), 32'(exp2_q.pop_front()));
    end
    if (rst && d4_out.valid && d4_out_ready) begin
      if (exp4_q.size() == 0) check("d4_extra_flit", 32'(d4_out.valid), 32'd0);
      else                    check("d4_out_flit", 32'(fl(d4_out)), 32'(exp4_q.pop_front()));
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Grant order for the N=4 all-requesting round-robin case.
  int rr4_order[5] = '{0, 1, 2, 3, 0};

  // ---------------- stimulus ----------------
  initial begin
    d2_in = '0; d4_in = '0;
    d2_out_ready = 1'b1; d4_out_ready = 1'b1;

    // Reset state, with requests present to show ready stays low in reset.
    d2_in[0] = mk(1'b0, 16'h0001);
    d4_in    = {mk(1'b1, 16'h3), mk(1'b1, 16'h2), mk(1'b1, 16'h1), mk(1'b1, 16'h0)};
    #3;
    check("rst_d2_ready",  32'(d2_ready), 32'h0);
    check("rst_d4_ready",  32'(d4_ready), 32'h0);
    check("rst_d2_valid",  32'(d2_out.valid), 32'h0);
    check("rst_d2_flit",   32'(fl(d2_out)), 32'h0);
    check("rst_d2_locked", 32'(d2_locked), 32'h0);
    check("rst_d2_owner",  32'(d2_owner), 32'h0);
    check("rst_d4_valid",  32'(d4_out.valid), 32'h0);
    step(); step();
    rst = 1'b1;
    d2_in = '0; d4_in = '0;
    step();

    // 3-flit packet from req0 while req1 waits with a single flit.
    d2_in[0] = mk(1'b0, 16'h000A);
    d2_in[1] = mk(1'b1, 16'h0011);
    settle();
    check("pkt_a_ready", 32'(d2_ready), 32'h1);
    exp2_q.push_back(17'h0000A);
    step();
    check("pkt_locked", 32'(d2_locked), 32'h1);
    check("pkt_owner",  32'(d2_owner), 32'h0);
    d2_in[0] = mk(1'b0, 16'h000B);
    settle();
    check("pkt_b_ready", 32'(d2_ready), 32'h1);
    exp2_q.push_back(17'h0000B);
    step();
    d2_in[0] = mk(1'b1, 16'h000C);
    settle();
    check("pkt_c_ready", 32'(d2_ready), 32'h1);
    exp2_q.push_back(17'h1000C);
    step();
    check("pkt_unlocked", 32'(d2_locked), 32'h0);
    d2_in[0] = '0;
    settle();
    check("pkt_req1_ready", 32'(d2_ready), 32'h2);
    exp2_q.push_back(17'h10011);
    step();
    d2_in[1] = mk(1'b1, 16'h0012);
    settle();
    check("pkt_req1b_ready", 32'(d2_ready), 32'h2);
    exp2_q.push_back(17'h10012);
    step();
    d2_in = '0;
    step();

    // N=4: everyone sends single-flit packets every cycle.
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < 4; i++) d4_in[i] = mk(1'b1, 16'((i << 8) | c));
      settle();
      check("rr4_ready", 32'(d4_ready), 32'(4'b0001 << rr4_order[c]));
      exp4_q.push_back(W'({1'b1, 16'((rr4_order[c] << 8) | c)}));
      step();
    end
    d4_in = '0;
    step();

    // Downstream stall of 3 cycles in the middle of a packet.
    d2_in[0] = mk(1'b0, 16'h0020);
    settle();
    check("stall_p0_ready", 32'(d2_ready), 32'h1);
    exp2_q.push_back(17'h00020);
    step();
    d2_in[0] = mk(1'b0, 16'h0021);
    d2_out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      settle();
      check("stall_ready", 32'(d2_ready), 32'h0);
      check("stall_valid", 32'(d2_out.valid), 32'h1);
      check("stall_hold",  32'(fl(d2_out)), 32'h00020);
      step();
    end
    d2_out_ready = 1'b1;
    settle();
    check("stall_p1_ready", 32'(d2_ready), 32'h1);
    exp2_q.push_back(17'h00021);
    step();
    check("stall_p1_loaded", 32'(fl(d2_out)), 32'h00021);
    d2_in[0] = mk(1'b1, 16'h0022);
    settle();
    check("stall_p2_ready", 32'(d2_ready), 32'h1);
    exp2_q.push_back(17'h10022);
    step();
    d2_in = '0;
    step();

    // Owner bubble of 2 cycles while req1 is waiting.
    d2_in[1] = mk(1'b1, 16'h0030);
    settle();
    check("bub_q_ready", 32'(d2_ready), 32'h2);
    exp2_q.push_back(17'h10030);
    step();
    d2_in[0] = mk(1'b0, 16'h0040);
    d2_in[1] = mk(1'b1, 16'h0050);
    settle();
    check("bub_r0_ready", 32'(d2_ready), 32'h1);
    exp2_q.push_back(17'h00040);
    step();
    d2_in[0] = '0;
    for (int b = 0; b < 2; b++) begin
      settle();
      check("bub_ready",  32'(d2_ready), 32'h1);
      check("bub_locked", 32'(d2_locked), 32'h1);
      step();
    end
    d2_in[0] = mk(1'b1, 16'h0041);
    settle();
    check("bub_r1_ready", 32'(d2_ready), 32'h1);
    exp2_q.push_back(17'h10041);
    step();
    d2_in[0] = '0;
    settle();
    check("bub_s0_ready", 32'(d2_ready), 32'h2);
    exp2_q.push_back(17'h10050);
    step();
    d2_in = '0;
    step();

    // Reset in the middle of a 4-flit packet owned by req1.
    d2_in[0] = mk(1'b1, 16'h005A);
    settle();
    check("rstm_v_ready", 32'(d2_ready), 32'h1);
    exp2_q.push_back(17'h1005A);
    step();
    d2_in[0] = mk(1'b1, 16'h0080);
    d2_in[1] = mk(1'b0, 16'h0060);
    settle();
    check("rstm_t0_ready", 32'(d2_ready), 32'h2);
    exp2_q.push_back(17'h00060);
    step();
    check("rstm_locked", 32'(d2_locked), 32'h1);
    check("rstm_owner",  32'(d2_owner), 32'h1);
    d2_in[1] = mk(1'b0, 16'h0061);
    settle();
    check("rstm_t1_ready", 32'(d2_ready), 32'h2);
    step();
    // Second flit sits in the output register and is discarded by reset.
    check("rstm_t1_loaded", 32'(fl(d2_out)), 32'h00061);
    rst = 1'b0;
    settle();
    check("rstm_valid",  32'(d2_out.valid), 32'h0);
    check("rstm_flit",   32'(fl(d2_out)), 32'h0);
    check("rstm_unlock", 32'(d2_locked), 32'h0);
    check("rstm_owner0", 32'(d2_owner), 32'h0);
    check("rstm_ready0", 32'(d2_ready), 32'h0);
    step();
    check("rstm_ready1", 32'(d2_ready), 32'h0);
    rst = 1'b1;
    d2_in[1] = mk(1'b0, 16'h0062);
    settle();
    check("rstm_w_ready", 32'(d2_ready), 32'h1);
    exp2_q.push_back(17'h10080);
    step();
    d2_in[0] = '0;
    d2_in[1] = mk(1'b1, 16'h0090);
    settle();
    check("rstm_u_ready", 32'(d2_ready), 32'h2);
    exp2_q.push_back(17'h10090);
    step();
    d2_in = '0;
    step(); step(); step();

    check("d2_drained", 32'(exp2_q.size()), 32'd0);
    check("d4_drained", 32'(exp4_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/osd_dii_pkt_arbiter.md
OSD_DII_PKT_ARBITER -- requirements
Module: osd_dii_pkt_arbiter

Interface
REQ-001 Parameter: N, default 2, number of requesting DII flit streams (CTMs, STMs, other debug modules); legal range 2..16.
REQ-002 Port: clk  input  1  single clock for all state.
REQ-003 Port: rst  input  1  reset, asynchronous assertion, active-low.
REQ-004 Port: debug_in  input  dii_flit[N]  requester flit streams (valid, last, data[15:0]).
REQ-005 Port: debug_in_ready  output  N  per-requester accept; a flit transfers when debug_in[i].valid and debug_in_ready[i] are both high.
REQ-006 Port: debug_out  output  dii_flit  merged, registered flit stream toward the debug interconnect.
REQ-007 Port: debug_out_ready  input  1  downstream accept for debug_out.
REQ-008 Port: owner  output  $clog2(N)  index of the requester currently holding the lock; valid only while locked is high.
REQ-009 Port: locked  output  1  high while a multi-flit packet is in progress.

Function
REQ-010 Arbitration granularity SHALL be the packet: once a packet's first flit is accepted, no other requester is accepted until that packet's last flit is accepted.
REQ-011 State machine SHALL have two states: IDLE and LOCK.
REQ-012 In IDLE, the grant SHALL go to the first requester with valid=1, searching from rr_ptr upward modulo N.
REQ-013 In IDLE, the grant SHALL take effect in the same cycle, so the first flit is accepted in the cycle it is presented if the output stage can take it.
REQ-014 Output stage can take a flit when out_valid=0 or debug_out_ready=1.
REQ-015 debug_in_ready[i] SHALL be high only for the granted or owning requester, and only when the output stage can take a flit; all other ready bits SHALL be 0.
REQ-016 IDLE to LOCK: on an accepted flit with last=0; owner is latched as the granted index.
REQ-017 IDLE stays IDLE on an accepted single-flit packet (last=1); rr_ptr SHALL become granted index+1 mod N.
REQ-018 LOCK to IDLE: on an accepted owner flit with last=1; rr_ptr SHALL become owner+1 mod N.
REQ-019 In LOCK, owner valid=0 (bubble) SHALL hold the lock with no ready to other requesters.
REQ-020 rr_ptr SHALL change only on acceptance of a last flit.
REQ-021 Output register: on accept, debug_out is loaded with the flit (valid=1) on the next edge; latency is exactly 1 cycle.
REQ-022 Output register: when debug_out_ready=1 and no new flit is accepted, debug_out.valid SHALL clear.
REQ-023 Output register: when debug_out_ready=0 and debug_out.valid=1, debug_out SHALL hold unchanged.
REQ-024 Sustained throughput SHALL be 1 flit/cycle when debug_out_ready stays high.
REQ-025 Simultaneous pop of the output register and load of a new flit in one cycle SHALL be supported without a bubble.
REQ-026 Flit fields SHALL pass unmodified; no re-packing and no length checking.
REQ-027 Behaviour when a requester drops valid mid-packet or N is out of range is not defined; not checked.

Reset
REQ-028 On rst low, asynchronously: state=IDLE, rr_ptr=0, owner=0, locked=0, debug_out.valid=0, debug_out.last=0, debug_out.data=0.
REQ-029 During reset, debug_in_ready SHALL be all 0.
REQ-030 Reset mid-packet SHALL discard the lock and the registered flit; after release, arbitration restarts from requester 0.

Structure
REQ-031 dii_flit SHALL come from dii_package; no new package typedefs.
REQ-032 The IDLE/LOCK state enum SHALL be local to the module.
REQ-033 Round-robin selection SHALL be one combinational sub-module, osd_rr_arb: inputs req[N] and ptr; outputs gnt_valid and gnt_idx.

Verification
REQ-034 Bench SHALL cover: N=2, req0 sends a 3-flit packet 0xA,0xB,0xC(last) while req1 holds valid -> out 0xA,0xB,0xC then req1's flits; debug_in_ready[1]=0 throughout LOCK.
REQ-035 Bench SHALL cover: N=4, all requesters send single-flit packets continuously -> grant order 0,1,2,3,0 with one flit per cycle.
REQ-036 Bench SHALL cover: debug_out_ready low 3 cycles mid-packet -> debug_out holds, debug_in_ready all 0 during the stall, no flit lost or duplicated.
REQ-037 Bench SHALL cover: owner bubble of 2 cycles in LOCK while req1 is valid -> no req1 flit accepted until owner's last flit, then req1 granted.
REQ-038 Bench SHALL cover: rst asserted after the 2nd of 4 flits -> debug_out.valid=0 and locked=0 immediately; after release, requester 0 wins first.
